// File: rtl/parser_pkg.sv
// rtl/parser_pkg.sv - shared parser widths, bit-count type and pad helper
package parser_pkg;

  localparam int PARSER_DATA_WIDTH = 32;

  typedef logic [$clog2(PARSER_DATA_WIDTH):0] bit_cnt_t;

  // Bits needed to reach the next byte boundary from (pos + amt).
  function automatic logic [2:0] pad_bits(input logic [2:0] pos, input logic [2:0] amt);
    logic [2:0] sum;
    sum = pos + amt;
    return 3'd0 - sum;
  endfunction

endpackage

// File: rtl/bit_funnel_shifter.sv
// rtl/bit_funnel_shifter.sv - left shift of the bit buffer plus insertion of a new word
module bit_funnel_shifter #(
  parameter int BUF_WIDTH = 64,
  parameter int IN_WIDTH  = 32,
  parameter int SW        = $clog2(BUF_WIDTH) + 1
) (
  input  logic [BUF_WIDTH-1:0] buf_in,
  input  logic [SW-1:0]        shift_amt,
  input  logic [IN_WIDTH-1:0]  append_word,
  input  logic [SW-1:0]        append_pos,
  output logic [BUF_WIDTH-1:0] buf_next
);

  logic [BUF_WIDTH-1:0] placed;

  // append_pos counts unread bits left after the shift; the word goes right below them.
  assign placed   = {append_word, {(BUF_WIDTH-IN_WIDTH){1'b0}}} >> append_pos;
  assign buf_next = (buf_in << shift_amt) | placed;

endmodule

// File: rtl/obu_bit_reader.sv
// rtl/obu_bit_reader.sv - bit-granular reader feeding the OBU header parsers
module obu_bit_reader
  import parser_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int BUF_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [PARSER_DATA_WIDTH-1:0] data_out,
  output bit_cnt_t                     avail,
  output logic                         win_full,
  input  logic                         pop,
  input  bit_cnt_t                     pop_len,
  input  logic                         pad,
  output logic                         aligned,
  output logic [31:0]                  bit_pos,
  output logic                         err
);

  localparam int W  = PARSER_DATA_WIDTH;
  localparam int LW = $clog2(BUF_WIDTH) + 1;
  localparam bit_cnt_t        W_CNT     = bit_cnt_t'(W);
  localparam logic [LW-1:0]   W_LVL     = LW'(W);
  localparam logic [LW-1:0]   READY_MAX = LW'(BUF_WIDTH - IN_WIDTH);
  localparam logic [LW-1:0]   IN_LVL    = LW'(IN_WIDTH);

  logic [BUF_WIDTH-1:0] shift_buf;
  logic [BUF_WIDTH-1:0] shift_buf_next;
  logic [LW-1:0]        level;
  logic [LW-1:0]        pop_amt;
  logic [LW-1:0]        pad_amt;
  logic [LW-1:0]        total;
  logic [LW-1:0]        consumed;
  logic [LW-1:0]        level_after;
  logic [IN_WIDTH-1:0]  append_word;
  logic                 illegal;
  logic                 push;

  assign in_ready = (level <= READY_MAX);
  assign push     = in_valid & in_ready;

  always_comb begin
    pop_amt     = pop ? LW'(pop_len) : '0;
    pad_amt     = pad ? LW'(pad_bits(bit_pos[2:0], pop ? pop_len[2:0] : 3'd0)) : '0;
    total       = pop_amt + pad_amt;
    // An illegal request retires nothing, but a push in the same cycle still lands.
    illegal     = (pop && (pop_len > W_CNT)) || (total > level);
    consumed    = illegal ? '0 : total;
    level_after = level - consumed;
    append_word = push ? in_data : '0;
  end

  bit_funnel_shifter #(
    .BUF_WIDTH (BUF_WIDTH),
    .IN_WIDTH  (IN_WIDTH),
    .SW        (LW)
  ) u_shifter (
    .buf_in      (shift_buf),
    .shift_amt   (consumed),
    .append_word (append_word),
    .append_pos  (level_after),
    .buf_next    (shift_buf_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_buf <= '0;
      level     <= '0;
      bit_pos   <= '0;
      err       <= 1'b0;
    end else if (flush) begin
      shift_buf <= '0;
      level     <= '0;
      bit_pos   <= '0;
      err       <= 1'b0;
    end else begin
      shift_buf <= shift_buf_next;
      level     <= level_after + (push ? IN_LVL : '0);
      bit_pos   <= bit_pos + 32'(consumed);
      err       <= err | illegal;
    end
  end

  // Consumed bits shift out with zero fill, so bits past level are always zero.
  assign data_out = shift_buf[BUF_WIDTH-1 -: W];
  assign avail    = (level >= W_LVL) ? W_CNT : bit_cnt_t'(level);
  assign win_full = (level >= W_LVL);
  assign aligned  = (bit_pos[2:0] == 3'd0);

endmodule
